// File: rtl/bist_response_analyzer_pkg.sv
// Package shared by the BIST response analyzer slice.
// Holds the FSM state encoding, the default MISR constants and the
// bit positions of the 12 observed CUT nodes inside the response vector.
package bist_response_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } ra_state_e;

    localparam int          DEF_WIDTH        = 12;
    localparam int          DEF_MISR_W       = 16;
    localparam logic [15:0] DEF_POLY         = 16'h1021;
    localparam logic [15:0] DEF_SEED         = 16'h0000;
    localparam int          DEF_NUM_PATTERNS = 64;
    localparam int          DEF_CNT_W        = 7;

    // Response bit order {Z, w, u, r, s, q, p, m, l, k, h, g}, g is the LSB.
    localparam int BIT_G = 0;
    localparam int BIT_H = 1;
    localparam int BIT_K = 2;
    localparam int BIT_L = 3;
    localparam int BIT_M = 4;
    localparam int BIT_P = 5;
    localparam int BIT_Q = 6;
    localparam int BIT_S = 7;
    localparam int BIT_R = 8;
    localparam int BIT_U = 9;
    localparam int BIT_W = 10;
    localparam int BIT_Z = 11;

endpackage

// File: rtl/bist_response_analyzer_if.sv
// Bus between the capture side (master: CUT/test controller) and the
// response analyzer (slave).
//   start, resp_valid, resp, golden  : master -> analyzer
//   resp_mask                        : master -> analyzer, only with BIST_RA_XMASK_EN
//   busy, done, pass, signature, pat_count : analyzer -> master
interface bist_response_analyzer_if #(
    parameter int WIDTH  = 12,
    parameter int MISR_W = 16,
    parameter int CNT_W  = 7
);
    logic              start;
    logic              resp_valid;
    logic [WIDTH-1:0]  resp;
    logic [MISR_W-1:0] golden;
`ifdef BIST_RA_XMASK_EN
    logic [WIDTH-1:0]  resp_mask;
`endif
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;
    logic [CNT_W-1:0]  pat_count;

`ifdef BIST_RA_XMASK_EN
    modport master (output start, resp_valid, resp, golden, resp_mask,
                    input  busy, done, pass, signature, pat_count);
    modport slave  (input  start, resp_valid, resp, golden, resp_mask,
                    output busy, done, pass, signature, pat_count);
`else
    modport master (output start, resp_valid, resp, golden,
                    input  busy, done, pass, signature, pat_count);
    modport slave  (input  start, resp_valid, resp, golden,
                    output busy, done, pass, signature, pat_count);
`endif
endinterface

// File: rtl/bist_response_analyzer_misr_reg.sv
// Parameterised MISR datapath.
//   clk, rst_n : clock, synchronous active-low reset (reset loads SEED)
//   load       : load SEED (takes priority over en)
//   en         : absorb din this cycle
//   din        : response word, zero-extended to MISR_W
//   sig        : current signature
module bist_response_analyzer_misr_reg #(
    parameter int                WIDTH  = 12,
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = 16'h1021,
    parameter logic [MISR_W-1:0] SEED   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [WIDTH-1:0]  din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_r;
    logic [MISR_W-1:0] din_ext_s;

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] cur,
                                                    input logic [MISR_W-1:0] data);
        logic [MISR_W-1:0] fb;
        fb = cur[MISR_W-1] ? POLY : {MISR_W{1'b0}};
        return {cur[MISR_W-2:0], 1'b0} ^ fb ^ data;
    endfunction

    // Zero-extend the response word to the register width.
    always_comb begin
        din_ext_s             = {MISR_W{1'b0}};
        din_ext_s[WIDTH-1:0]  = din;
    end

    // Signature register: reset/load to SEED, otherwise shift-and-fold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_r <= SEED;
        end else if (load) begin
            sig_r <= SEED;
        end else if (en) begin
            sig_r <= misr_next(sig_r, din_ext_s);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts NUM_PATTERNS response words into a MISR
// signature and compares it with a golden value.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of bist_response_analyzer_if (start/resp/golden in,
//           busy/done/pass/signature/pat_count out)
// Optional build macro BIST_RA_XMASK_EN adds bus.resp_mask; masked bits
// (mask=1) are forced to 0 before compaction.
module bist_response_analyzer
    import bist_response_analyzer_pkg::*;
#(
    parameter int                WIDTH        = DEF_WIDTH,
    parameter int                MISR_W       = DEF_MISR_W,
    parameter logic [MISR_W-1:0] POLY         = DEF_POLY,
    parameter logic [MISR_W-1:0] SEED         = DEF_SEED,
    parameter int                NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int                CNT_W        = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bist_response_analyzer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    ra_state_e        state_r;
    ra_state_e        state_next_s;
    logic             load_s;
    logic             absorb_s;
    logic [CNT_W-1:0] cnt_r;
    logic             pass_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] resp_eff_s;
    logic [MISR_W-1:0] sig_s;

    // Apply the optional X-mask to the incoming response.
    always_comb begin
`ifdef BIST_RA_XMASK_EN
        resp_eff_s = bus.resp & ~bus.resp_mask;
`else
        resp_eff_s = bus.resp;
`endif
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        absorb_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_next_s = ST_COMPACT;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_COMPACT: begin
                if (bus.resp_valid) begin
                    absorb_s = 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        state_next_s = ST_COMPARE;
                    end else begin
                        state_next_s = ST_COMPACT;
                    end
                end else begin
                    state_next_s = ST_COMPACT;
                end
            end
            ST_COMPARE: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus busy/done registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_COMPACT) || (state_next_s == ST_COMPARE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Absorbed-pattern counter; the FSM leaves COMPACT on the last one so it
    // never passes NUM_PATTERNS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (absorb_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Pass flag: cleared on (re)start, captured in COMPARE, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_r <= 1'b0;
        end else if (load_s) begin
            pass_r <= 1'b0;
        end else if (state_r == ST_COMPARE) begin
            pass_r <= (sig_s == bus.golden);
        end else begin
            pass_r <= pass_r;
        end
    end

    bist_response_analyzer_misr_reg #(
        .WIDTH  (WIDTH),
        .MISR_W (MISR_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .en    (absorb_s),
        .din   (resp_eff_s),
        .sig   (sig_s)
    );

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.signature = sig_s;
    assign bus.pat_count = cnt_r;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Randomised self-checking bench for bist_response_analyzer (64 patterns,
// POLY 16'h1021, SEED 0). Expected signatures come from an arithmetic model
// of the MISR (multiply by two, reduce by the polynomial, xor the response).
module tb_bist_response_analyzer;

    localparam int NP = 64;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    bist_response_analyzer_if #(.WIDTH(12), .MISR_W(16), .CNT_W(7)) bus ();

    bist_response_analyzer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Polynomial arithmetic view of one absorb: sig*x mod P(x), plus resp.
    function automatic logic [15:0] ref_absorb(input logic [15:0] s, input logic [11:0] r);
        int unsigned v;
        v = s;
        v = v * 2;
        if (v >= 65536) v = (v - 65536) ^ 32'h0000_1021;
        v = v ^ r;
        return v[15:0];
    endfunction

    task automatic set_mask(input logic [11:0] m);
`ifdef BIST_RA_XMASK_EN
        bus.resp_mask = m;
`endif
    endtask

    // mode: 0 random, 1 all zero, 2 impulse then zeros, 3 all ones fully masked.
    // abort_at >= 0 asserts reset after that many absorbed responses.
    task automatic do_run(input int mode, input bit bubbles, input bit match, input int abort_at);
        logic [11:0] rv[NP];
        logic [11:0] mv[NP];
        logic [15:0] m;
        logic [15:0] final_sig;
        logic [15:0] gold;
        int          absorbed;
        int          cyc;
        bit          v;
        for (int i = 0; i < NP; i++) begin
            case (mode)
                1:       rv[i] = 12'h000;
                2:       rv[i] = (i == 0) ? 12'h001 : 12'h000;
                3:       rv[i] = 12'hFFF;
                default: rv[i] = 12'($urandom);
            endcase
`ifdef BIST_RA_XMASK_EN
            mv[i] = (mode == 3) ? 12'hFFF : ((mode == 0) ? 12'($urandom & $urandom) : 12'h000);
`else
            mv[i] = 12'h000;
`endif
        end
        final_sig = 16'h0000;
        for (int i = 0; i < NP; i++) final_sig = ref_absorb(final_sig, rv[i] & ~mv[i]);
        gold = match ? final_sig : (final_sig ^ 16'h0001);

        bus.golden = gold;
        bus.start  = 1'b1;
        step();
        check("start_busy", bus.busy, 1);
        check("start_done", bus.done, 0);
        check("start_pass", bus.pass, 0);
        check("start_cnt", bus.pat_count, 0);
        check("start_sig", bus.signature, 16'h0000);
        m = 16'h0000;
        absorbed = 0;
        cyc = 0;
        while (absorbed < NP && cyc < 400) begin
            v = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.resp_valid = v;
            bus.resp       = v ? rv[absorbed] : 12'($urandom);
            set_mask(v ? mv[absorbed] : 12'($urandom));
            bus.start      = ($urandom_range(0, 7) == 0);
            step();
            cyc++;
            if (v) begin
                m = ref_absorb(m, rv[absorbed] & ~mv[absorbed]);
                absorbed++;
            end
            check("run_sig", bus.signature, m);
            check("run_cnt", bus.pat_count, absorbed);
            if (mode == 2 && v && absorbed == 16) check("impulse_16", bus.signature, 16'h8000);
            if (mode == 2 && v && absorbed == 17) check("impulse_17", bus.signature, 16'h1021);
            if (absorbed == abort_at) begin
                bus.resp_valid = 1'b0;
                bus.start      = 1'b0;
                rst_n          = 1'b0;
                step();
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_pass", bus.pass, 0);
                check("rst_sig", bus.signature, 16'h0000);
                check("rst_cnt", bus.pat_count, 0);
                rst_n = 1'b1;
                step();
                return;
            end
        end
        check("absorb_budget", absorbed, NP);
        bus.resp_valid = 1'b0;
        bus.start      = 1'b0;
        check("compare_busy", bus.busy, 1);
        check("compare_done", bus.done, 0);
        step();
        cyc++;
        check("done_flag", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_pass", bus.pass, match);
        check("done_sig", bus.signature, final_sig);
        if (!bubbles) check("done_latency", cyc, NP + 1);
        bus.resp_valid = 1'b1;
        bus.resp       = 12'($urandom);
        step();
        bus.resp_valid = 1'b0;
        check("hold_sig", bus.signature, final_sig);
        check("hold_cnt", bus.pat_count, NP);
        check("hold_done", bus.done, 1);
        check("hold_pass", bus.pass, match);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp       = 12'h000;
        bus.golden     = 16'h0000;
        set_mask(12'h000);
        step();
        step();
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_pass", bus.pass, 0);
        check("reset_sig", bus.signature, 16'h0000);
        check("reset_cnt", bus.pat_count, 0);
        rst_n = 1'b1;
        step();
        check("idle_stray_valid", bus.pat_count, 0);

        do_run(1, 1'b0, 1'b1, -1);
        do_run(2, 1'b0, 1'b1, -1);
        do_run(2, 1'b0, 1'b0, -1);
        do_run(0, 1'b1, 1'b1, -1);
        do_run(0, 1'b1, 1'b0, -1);
        do_run(0, 1'b1, 1'b1, 20);
        do_run(0, 1'b0, 1'b1, -1);
`ifdef BIST_RA_XMASK_EN
        do_run(3, 1'b1, 1'b1, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
